// File: rtl/bsg_manycore_host_link_bridge.sv
// Host endpoint on the manycore loader io port: credit-gated request injection, return collection,
// and buffering/acknowledgement of manycore-to-host requests. Optional watchdog: BSG_HOST_BRIDGE_TIMEOUT_EN.

module bsg_host_bridge_fifo #(
   parameter int unsigned width_p = 8,
   parameter int unsigned els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               full_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);
   localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  r_mem [els_p];
   logic [ptr_w_lp-1:0] r_wptr, r_rptr;
   logic [cnt_w_lp-1:0] r_cnt;
   logic                w_push, w_pop;

   // Push is refused on the registered full flag, even if a pop happens in the same cycle
   assign full_o = (r_cnt == cnt_w_lp'(els_p));
   assign v_o    = (r_cnt != '0);
   assign w_push = v_i & ~full_o;
   assign w_pop  = yumi_i & v_o;
   assign data_o = r_mem[r_rptr];

   function automatic logic [ptr_w_lp-1:0] f_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= f_inc(r_wptr);
         if (w_pop)  r_rptr <= f_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + cnt_w_lp'(1);
            2'b01:   r_cnt <= r_cnt - cnt_w_lp'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_i;
   end
endmodule

module bsg_manycore_host_link_bridge #(
   parameter int unsigned addr_width_p      = 28,
   parameter int unsigned data_width_p      = 32,
   parameter int unsigned x_cord_width_p    = 4,
   parameter int unsigned y_cord_width_p    = 4,
   parameter int unsigned load_id_width_p   = 5,
   parameter int unsigned max_out_credits_p = 16,
   parameter int unsigned rsp_fifo_els_p    = 4,
   parameter int unsigned in_fifo_els_p     = 4,
   parameter int unsigned timeout_cycles_p  = 1024,
   localparam int unsigned packet_width_lp = addr_width_p + 2 + load_id_width_p + data_width_p
                                             + 2 * y_cord_width_p + 2 * x_cord_width_p,
   localparam int unsigned return_packet_width_lp = 2 + data_width_p + load_id_width_p
                                                    + y_cord_width_p + x_cord_width_p,
   localparam int unsigned link_sif_width_lp = packet_width_lp + return_packet_width_lp + 4,
   localparam int unsigned credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [link_sif_width_lp-1:0]      link_sif_i,
   output logic [link_sif_width_lp-1:0]      link_sif_o,
   input  logic [x_cord_width_p-1:0]         my_x_i,
   input  logic [y_cord_width_p-1:0]         my_y_i,
   input  logic                              host_req_v_i,
   input  logic [packet_width_lp-1:0]        host_req_data_i,
   output logic                              host_req_ready_o,
   output logic                              host_rsp_v_o,
   output logic [return_packet_width_lp-1:0] host_rsp_data_o,
   input  logic                              host_rsp_yumi_i,
   output logic                              host_in_v_o,
   output logic [packet_width_lp-1:0]        host_in_data_o,
   input  logic                              host_in_yumi_i,
   output logic [credit_width_lp-1:0]        out_credits_o,
   output logic                              idle_o,
   output logic                              timeout_o
);
   localparam logic [1:0] e_return_credit = 2'b00;

   typedef struct packed {
      logic [addr_width_p-1:0]    addr;
      logic [1:0]                 op;
      logic [load_id_width_p-1:0] load_id;
      logic [data_width_p-1:0]    payload;
      logic [y_cord_width_p-1:0]  src_y_cord;
      logic [x_cord_width_p-1:0]  src_x_cord;
      logic [y_cord_width_p-1:0]  y_cord;
      logic [x_cord_width_p-1:0]  x_cord;
   } pkt_s;

   typedef struct packed {
      logic [1:0]                 pkt_type;
      logic [data_width_p-1:0]    data;
      logic [load_id_width_p-1:0] load_id;
      logic [y_cord_width_p-1:0]  y_cord;
      logic [x_cord_width_p-1:0]  x_cord;
   } ret_pkt_s;

   typedef struct packed {
      logic v;
      pkt_s data;
      logic ready_and_rev;
   } fwd_s;

   typedef struct packed {
      logic     v;
      ret_pkt_s data;
      logic     ready_and_rev;
   } rev_s;

   typedef struct packed {
      fwd_s fwd;
      rev_s rev;
   } link_sif_s;

   link_sif_s                  w_li, w_lo;
   logic [credit_width_lp-1:0] r_credits;
   logic                       r_ack_v;
   ret_pkt_s                   r_ack_pkt;
   logic [packet_width_lp-1:0] w_fwd_data;
   logic w_fwd_full, w_fwd_v, w_rsp_full, w_in_full;
   logic w_host_acc, w_ret_acc, w_in_ready, w_in_acc, w_credits_full;
   logic w_unused_cord;

   assign w_li          = link_sif_i;
   assign link_sif_o    = w_lo;
   assign w_unused_cord = ^{my_x_i, my_y_i};

   assign w_credits_full   = (r_credits == credit_width_lp'(max_out_credits_p));
   assign host_req_ready_o = ~w_fwd_full & (r_credits != '0);
   assign w_host_acc       = host_req_v_i & host_req_ready_o;
   assign w_ret_acc        = w_li.rev.v & ~w_rsp_full;
   // Incoming requests wait for the ack slot, so ready never depends on the rev handshake
   assign w_in_ready       = ~w_in_full & ~r_ack_v;
   assign w_in_acc         = w_li.fwd.v & w_in_ready;
   assign out_credits_o    = r_credits;
   assign idle_o           = w_credits_full & ~w_fwd_v & ~host_rsp_v_o & ~host_in_v_o;

   always_comb begin
      w_lo                   = '0;
      w_lo.fwd.v             = w_fwd_v;
      w_lo.fwd.data          = w_fwd_data;
      w_lo.fwd.ready_and_rev = w_in_ready;
      w_lo.rev.v             = r_ack_v;
      w_lo.rev.data          = r_ack_pkt;
      w_lo.rev.ready_and_rev = ~w_rsp_full;
   end

   bsg_host_bridge_fifo #(.width_p(packet_width_lp), .els_p(2)) u_fwd_out (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(w_host_acc), .data_i(host_req_data_i),
      .full_o(w_fwd_full), .v_o(w_fwd_v), .data_o(w_fwd_data),
      .yumi_i(w_fwd_v & w_li.fwd.ready_and_rev)
   );

   bsg_host_bridge_fifo #(.width_p(return_packet_width_lp), .els_p(rsp_fifo_els_p)) u_rsp (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(w_li.rev.v), .data_i(w_li.rev.data),
      .full_o(w_rsp_full), .v_o(host_rsp_v_o), .data_o(host_rsp_data_o),
      .yumi_i(host_rsp_yumi_i)
   );

   bsg_host_bridge_fifo #(.width_p(packet_width_lp), .els_p(in_fifo_els_p)) u_in (
      .clk_i(clk_i), .reset_i(reset_i),
      .v_i(w_in_acc), .data_i(w_li.fwd.data),
      .full_o(w_in_full), .v_o(host_in_v_o), .data_o(host_in_data_o),
      .yumi_i(host_in_yumi_i)
   );

   // Outstanding-credit counter; an unexpected return at max saturates
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_credits <= credit_width_lp'(max_out_credits_p);
      end else begin
         case ({w_host_acc, w_ret_acc})
            2'b10:   r_credits <= r_credits - credit_width_lp'(1);
            2'b01:   r_credits <= w_credits_full ? r_credits : r_credits + credit_width_lp'(1);
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ack_v   <= 1'b0;
         r_ack_pkt <= '0;
      end else if (w_in_acc) begin
         r_ack_v            <= 1'b1;
         r_ack_pkt.pkt_type <= e_return_credit;
         r_ack_pkt.data     <= '0;
         r_ack_pkt.load_id  <= w_li.fwd.data.load_id;
         r_ack_pkt.y_cord   <= w_li.fwd.data.src_y_cord;
         r_ack_pkt.x_cord   <= w_li.fwd.data.src_x_cord;
      end else if (r_ack_v & w_li.rev.ready_and_rev) begin
         r_ack_v <= 1'b0;
      end
   end

`ifdef BSG_HOST_BRIDGE_TIMEOUT_EN
   localparam int unsigned tmo_width_lp = $clog2(timeout_cycles_p + 1);

   logic [tmo_width_lp-1:0] r_tmo_cnt, w_tmo_cnt_n;
   logic                    r_timeout;

   always_comb begin
      w_tmo_cnt_n = r_tmo_cnt;
      if (w_ret_acc || w_credits_full)
         w_tmo_cnt_n = '0;
      else if (r_tmo_cnt != tmo_width_lp'(timeout_cycles_p))
         w_tmo_cnt_n = r_tmo_cnt + tmo_width_lp'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tmo_cnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_tmo_cnt <= w_tmo_cnt_n;
         if (w_tmo_cnt_n == tmo_width_lp'(timeout_cycles_p)) r_timeout <= 1'b1;
      end
   end

   assign timeout_o = r_timeout;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (timeout_cycles_p == 0);
   assign timeout_o    = 1'b0;
`endif

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!reset_i) begin
         if (w_ret_acc && !w_host_acc && w_credits_full)
            $error("host bridge: return packet received with credits already at max");
         assert (!(host_rsp_yumi_i && !host_rsp_v_o)) else $error("host bridge: rsp yumi without valid");
         assert (!(host_in_yumi_i && !host_in_v_o)) else $error("host bridge: in yumi without valid");
      end
   end
`endif
endmodule

// File: tb/tb_bsg_manycore_host_link_bridge.sv
// Scoreboard bench for bsg_manycore_host_link_bridge: directed stimulus, queue-based monitors.

module tb_bsg_manycore_host_link_bridge;
   localparam int unsigned AW = 10, DW = 32, XW = 4, YW = 4, LW = 5;
   localparam int unsigned PW = AW + 2 + LW + DW + 2 * YW + 2 * XW;
   localparam int unsigned RW = 2 + DW + LW + YW + XW;
   localparam int unsigned SW = PW + RW + 4;
`ifdef BSG_HOST_BRIDGE_TIMEOUT_EN
   localparam bit tmo_en = 1'b1;
`else
   localparam bit tmo_en = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    op;
      logic [LW-1:0] load_id;
      logic [DW-1:0] payload;
      logic [YW-1:0] src_y_cord;
      logic [XW-1:0] src_x_cord;
      logic [YW-1:0] y_cord;
      logic [XW-1:0] x_cord;
   } pkt_s;

   typedef struct packed {
      logic [1:0]    pkt_type;
      logic [DW-1:0] data;
      logic [LW-1:0] load_id;
      logic [YW-1:0] y_cord;
      logic [XW-1:0] x_cord;
   } ret_s;

   typedef struct packed {
      logic v;  pkt_s fdata; logic frdy;
      logic rv; ret_s rdata; logic rrdy;
   } link_s;

   logic clk, reset;
   logic li_fwd_v, li_fwd_rdy, li_rev_v, li_rev_rdy;
   pkt_s li_fwd_data, host_req_data;
   ret_s li_rev_data;
   logic [SW-1:0] link_in, link_out;
   link_s lo;
   logic host_req_v, host_req_ready, host_rsp_v, host_in_v, idle, timeout;
   logic rsp_yumi_en, in_yumi_en, rsp_yumi, in_yumi;
   ret_s host_rsp_data;
   pkt_s host_in_data;
   logic [4:0] credits;
   logic [XW-1:0] my_x;
   logic [YW-1:0] my_y;

   int checks = 0, failures = 0;
   pkt_s exp_fwd[$];
   pkt_s exp_in[$];
   ret_s exp_rsp[$];
   ret_s exp_ack[$];

   assign link_in  = {li_fwd_v, li_fwd_data, li_fwd_rdy, li_rev_v, li_rev_data, li_rev_rdy};
   assign lo       = link_out;
   assign rsp_yumi = rsp_yumi_en & host_rsp_v;
   assign in_yumi  = in_yumi_en & host_in_v;

   bsg_manycore_host_link_bridge #(
      .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
      .load_id_width_p(LW), .max_out_credits_p(16), .rsp_fifo_els_p(4), .in_fifo_els_p(4),
      .timeout_cycles_p(8)
   ) dut (
      .clk_i(clk), .reset_i(reset), .link_sif_i(link_in), .link_sif_o(link_out),
      .my_x_i(my_x), .my_y_i(my_y),
      .host_req_v_i(host_req_v), .host_req_data_i(host_req_data), .host_req_ready_o(host_req_ready),
      .host_rsp_v_o(host_rsp_v), .host_rsp_data_o(host_rsp_data), .host_rsp_yumi_i(rsp_yumi),
      .host_in_v_o(host_in_v), .host_in_data_o(host_in_data), .host_in_yumi_i(in_yumi),
      .out_credits_o(credits), .idle_o(idle), .timeout_o(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic pkt_s mk_pkt(input int i);
      pkt_s p;
      p.addr       = AW'(i * 37 + 1);
      p.op         = 2'd1;
      p.load_id    = LW'(i);
      p.payload    = 32'hA500_0000 + DW'(i);
      p.src_y_cord = '0;
      p.src_x_cord = '0;
      p.y_cord     = YW'(1 + i % 3);
      p.x_cord     = XW'(i % 4);
      return p;
   endfunction

   function automatic ret_s mk_ret(input int i);
      ret_s r;
      r.pkt_type = 2'd1;
      r.data     = 32'hC0DE_0000 + DW'(i);
      r.load_id  = LW'(i);
      r.y_cord   = '0;
      r.x_cord   = '0;
      return r;
   endfunction

   function automatic pkt_s mk_in(input int sx, input int sy, input int lid, input logic [DW-1:0] d);
      pkt_s p;
      p.addr = AW'(10'h55); p.op = 2'd1; p.load_id = LW'(lid); p.payload = d;
      p.src_y_cord = YW'(sy); p.src_x_cord = XW'(sx); p.y_cord = '0; p.x_cord = '0;
      return p;
   endfunction

   function automatic ret_s mk_ack(input int sx, input int sy, input int lid);
      ret_s r;
      r.pkt_type = 2'd0; r.data = '0; r.load_id = LW'(lid); r.y_cord = YW'(sy); r.x_cord = XW'(sx);
      return r;
   endfunction

   // Monitors: pop the expected entry whenever a handshake is about to complete
   always @(negedge clk) begin
      if (!reset) begin
         if (lo.v && li_fwd_rdy) begin
            if (exp_fwd.size() == 0) begin
               checks++; failures++;
               $display("FAIL fwd_unexpected act=%0h exp=none", lo.fdata);
            end else chk("fwd_pkt", lo.fdata, exp_fwd.pop_front());
         end
         if (lo.rv && li_rev_rdy) begin
            if (exp_ack.size() == 0) begin
               checks++; failures++;
               $display("FAIL ack_unexpected act=%0h exp=none", lo.rdata);
            end else chk("ack_pkt", lo.rdata, exp_ack.pop_front());
         end
         if (rsp_yumi) begin
            if (exp_rsp.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected act=%0h exp=none", host_rsp_data);
            end else chk("rsp_pkt", host_rsp_data, exp_rsp.pop_front());
         end
         if (in_yumi) begin
            if (exp_in.size() == 0) begin
               checks++; failures++;
               $display("FAIL in_unexpected act=%0h exp=none", host_in_data);
            end else chk("in_pkt", host_in_data, exp_in.pop_front());
         end
      end
   end

   initial begin
      pkt_s pa, pb;
      reset = 1'b1; my_x = '0; my_y = '0;
      li_fwd_v = 0; li_fwd_data = '0; li_fwd_rdy = 1; li_rev_v = 0; li_rev_data = '0; li_rev_rdy = 1;
      host_req_v = 0; host_req_data = '0; rsp_yumi_en = 0; in_yumi_en = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_credits", credits, 16);
      chk("rst_idle", idle, 1);
      chk("rst_req_ready", host_req_ready, 1);
      chk("rst_fwd_v", lo.v, 0);
      chk("rst_rev_v", lo.rv, 0);
      chk("rst_rsp_v", host_rsp_v, 0);
      chk("rst_in_v", host_in_v, 0);
      chk("rst_timeout", timeout, 0);

      // Exhaust all 16 credits
      for (int i = 0; i < 16; i++) begin
         host_req_v = 1; host_req_data = mk_pkt(i);
         chk("req_ready_fill", host_req_ready, 1);
         exp_fwd.push_back(mk_pkt(i));
         tick();
         if (i == 0) begin
            chk("fwd_latency_v", lo.v, 1);
            chk("fwd_latency_data", lo.fdata, mk_pkt(0));
         end
      end
      host_req_data = mk_pkt(16);
      chk("credits_zero", credits, 0);
      chk("req_ready_zero", host_req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("req_held", host_req_ready, 0);
      end
      li_rev_v = 1; li_rev_data = mk_ret(0); exp_rsp.push_back(mk_ret(0));
      tick();
      li_rev_v = 0;
      chk("credits_one", credits, 1);
      chk("req_ready_one", host_req_ready, 1);
      exp_fwd.push_back(mk_pkt(16));
      tick();
      host_req_v = 0;
      chk("credits_after_17th", credits, 0);
      rsp_yumi_en = 1; tick(); rsp_yumi_en = 0;

      // Return five credits
      rsp_yumi_en = 1;
      for (int i = 1; i <= 5; i++) begin
         li_rev_v = 1; li_rev_data = mk_ret(i); exp_rsp.push_back(mk_ret(i));
         tick();
      end
      li_rev_v = 0;
      tick(); tick();
      rsp_yumi_en = 0;
      chk("credits_five", credits, 5);
      chk("rsp_drained", host_rsp_v, 0);

      // Simultaneous accept and return
      host_req_v = 1; host_req_data = mk_pkt(17); exp_fwd.push_back(mk_pkt(17));
      li_rev_v = 1; li_rev_data = mk_ret(6); exp_rsp.push_back(mk_ret(6));
      tick();
      host_req_v = 0; li_rev_v = 0;
      chk("credits_same_cycle", credits, 5);
      chk("rsp_v_one", host_rsp_v, 1);
      chk("rsp_head_data", host_rsp_data, mk_ret(6));

      // Fill the response FIFO
      for (int i = 7; i <= 9; i++) begin
         li_rev_v = 1; li_rev_data = mk_ret(i);
         chk("rsp_ready_open", lo.rrdy, 1);
         exp_rsp.push_back(mk_ret(i));
         tick();
      end
      li_rev_data = mk_ret(10);
      chk("rsp_full_ready", lo.rrdy, 0);
      chk("credits_eight", credits, 8);
      tick();
      chk("rsp_full_held", lo.rrdy, 0);
      chk("credits_held", credits, 8);
      rsp_yumi_en = 1; tick(); rsp_yumi_en = 0;
      chk("rsp_ready_after_pop", lo.rrdy, 1);
      exp_rsp.push_back(mk_ret(10));
      tick();
      li_rev_v = 0;
      chk("credits_nine", credits, 9);
      rsp_yumi_en = 1;
      repeat (5) tick();
      for (int i = 11; i <= 17; i++) begin
         li_rev_v = 1; li_rev_data = mk_ret(i); exp_rsp.push_back(mk_ret(i));
         tick();
      end
      li_rev_v = 0;
      repeat (3) tick();
      rsp_yumi_en = 0;
      chk("credits_full", credits, 16);
      chk("idle_again", idle, 1);

      // Manycore-initiated request and its credit ack
      li_rev_rdy = 0;
      pa = mk_in(2, 3, 7, 32'h1234_5678);
      pb = mk_in(5, 1, 3, 32'h0BAD_F00D);
      li_fwd_v = 1; li_fwd_data = pa;
      chk("in_ready", lo.frdy, 1);
      exp_in.push_back(pa); exp_ack.push_back(mk_ack(2, 3, 7));
      tick();
      li_fwd_data = pb;
      chk("host_in_v", host_in_v, 1);
      chk("host_in_data", host_in_data, pa);
      chk("ack_v", lo.rv, 1);
      chk("ack_data", lo.rdata, mk_ack(2, 3, 7));
      for (int k = 0; k < 10; k++) begin
         chk("in_ready_blocked", lo.frdy, 0);
         tick();
      end
      li_rev_rdy = 1;
      tick();
      chk("in_ready_reopen", lo.frdy, 1);
      exp_in.push_back(pb); exp_ack.push_back(mk_ack(5, 1, 3));
      tick();
      li_fwd_v = 0;
      chk("ack2_v", lo.rv, 1);
      tick();
      chk("ack2_cleared", lo.rv, 0);
      in_yumi_en = 1;
      repeat (3) tick();
      in_yumi_en = 0;
      chk("in_drained", host_in_v, 0);

      // Asynchronous reset with a packet stuck in the forward FIFO
      li_fwd_rdy = 0;
      host_req_v = 1; host_req_data = mk_pkt(18);
      tick();
      host_req_v = 0;
      chk("pre_rst_credits", credits, 15);
      chk("pre_rst_fwd_v", lo.v, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_credits", credits, 16);
      chk("async_rst_fwd_v", lo.v, 0);
      chk("async_rst_idle", idle, 1);
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
      li_fwd_rdy = 1;
      chk("post_rst_timeout", timeout, 0);

      // Watchdog: one request, no return
      host_req_v = 1; host_req_data = mk_pkt(19); exp_fwd.push_back(mk_pkt(19));
      tick();
      host_req_v = 0;
      chk("tmo_credits", credits, 15);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("timeout_rise", timeout, (tmo_en && k == 8) ? 1 : 0);
      end
      li_rev_v = 1; li_rev_data = mk_ret(20); exp_rsp.push_back(mk_ret(20));
      rsp_yumi_en = 1;
      tick();
      li_rev_v = 0;
      chk("tmo_credits_back", credits, 16);
      repeat (3) tick();
      rsp_yumi_en = 0;
      chk("timeout_sticky", timeout, tmo_en ? 1 : 0);

      chk("exp_fwd_empty", exp_fwd.size(), 0);
      chk("exp_rsp_empty", exp_rsp.size(), 0);
      chk("exp_in_empty", exp_in.size(), 0);
      chk("exp_ack_empty", exp_ack.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bsg_manycore_host_link_bridge.md
Name: bsg_manycore_host_link_bridge

Overview:
- Host-side endpoint on the manycore loader port: the io link at x=0, north edge.
- Forward path: accepts host-formed request packets and injects them into the manycore network, gated by an outstanding-credit counter.
- Return path: collects return packets into a host response FIFO.
- Manycore-initiated requests to the host (prints, finish, and similar) are buffered in a host-readable FIFO and acknowledged on the reverse link.

Parameters:
- addr_width_p, "inv": word address width of a manycore packet.
- data_width_p, "inv": packet data width.
- x_cord_width_p, "inv": x coordinate width.
- y_cord_width_p, "inv": y coordinate width.
- load_id_width_p, "inv": load id width.
- max_out_credits_p, 16: maximum outstanding forward requests.
- rsp_fifo_els_p, 4: host response FIFO depth.
- in_fifo_els_p, 4: depth of the FIFO for manycore-to-host requests.
- timeout_cycles_p, 1024: watchdog limit; used only with the optional feature.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: reset, asynchronous, active-high.
- link_sif_i, in, link_sif_width_lp: from the manycore io port. Carries fwd {v, data, ready_and_rev} and rev {v, data, ready_and_rev}.
- link_sif_o, out, link_sif_width_lp: to the manycore io port, same structure.
- my_x_i, in, x_cord_width_p: bridge x coordinate.
- my_y_i, in, y_cord_width_p: bridge y coordinate.
- host_req_v_i, in, 1: host request valid.
- host_req_data_i, in, packet_width_lp: host request, a bsg_manycore_packet_s.
- host_req_ready_o, out, 1: request accepted when v and ready are both high.
- host_rsp_v_o, out, 1: response FIFO head valid.
- host_rsp_data_o, out, return_packet_width_lp: response FIFO head.
- host_rsp_yumi_i, in, 1: host pops the response FIFO head.
- host_in_v_o, out, 1: manycore-request FIFO head valid.
- host_in_data_o, out, packet_width_lp: manycore-request FIFO head.
- host_in_yumi_i, in, 1: host pops the manycore-request FIFO head.
- out_credits_o, out, clog2(max_out_credits_p+1): available credits.
- idle_o, out, 1: credits full and all FIFOs empty.
- timeout_o, out, 1: sticky watchdog flag.

Behaviour:
- Reset values:
  - out_credits_o = max_out_credits_p.
  - All FIFOs empty.
  - All valid outputs 0; timeout_o 0; idle_o 1.
  - link_sif_o fwd.v = 0 and rev.v = 0.
- Forward injection:
  - The outgoing fwd channel is a 2-entry registered FIFO (fwd_out_fifo).
  - host_req_ready_o = fwd_out_fifo not full AND out_credits_o != 0.
  - On accept, credits decrement and the packet enters the FIFO. The first cycle it can appear on link_sif_o.fwd is the next cycle (latency 1).
  - fwd.v = FIFO not empty. Dequeue on fwd.v AND link_sif_i.fwd.ready_and_rev.
- Credit return:
  - link_sif_o.rev.ready_and_rev = response FIFO not full.
  - Each accepted return packet enqueues into the response FIFO and increments credits.
  - Simultaneous accept and return leaves credits unchanged.
  - A return arriving while credits = max is a protocol error: credits saturate and `ifndef SYNTHESIS raises $error.
  - credits = 0 holds host_req_ready_o low.
- Incoming requests:
  - link_sif_o.fwd.ready_and_rev = in FIFO not full AND ack register empty.
  - On accept:
    - The packet is enqueued into the in FIFO.
    - The 1-entry ack register loads a return packet: pkt_type = e_return_credit, data = 0, load_id = request load_id, x_cord = request src_x_cord, y_cord = request src_y_cord.
  - link_sif_o.rev.v = ack register full. The register clears on rev.v AND link_sif_i.rev.ready_and_rev. The ready above is not asserted in that clear cycle, so there is no combinational path.
  - Consequence: at most one incoming request is accepted per 2 cycles when rev is continuously ready. This is acceptable for host-bound traffic.
- Host FIFOs:
  - A pop (yumi) is only legal when the corresponding valid is high; an assertion checks this.
  - Push and pop of a full FIFO in the same cycle is not allowed. Ready is based on the registered full flag.
- idle_o is combinational from the registered state.
- Reset asserted mid-transfer:
  - All state clears immediately and asynchronously.
  - In-flight packets are dropped; credits are restored to max.

Optional Feature:
- Macro: BSG_HOST_BRIDGE_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(timeout_cycles_p+1) increments each cycle while out_credits_o < max and no return packet is accepted.
  - It clears on any accepted return packet or when credits are full.
  - On reaching timeout_cycles_p, timeout_o sets and stays set until reset.
  - The counter saturates at the limit.
- Disabled: the counter logic is absent and timeout_o is tied to 0.

Test Plan:
- Reset, then idle checks -> out_credits_o = 16, idle_o = 1, host_req_ready_o = 1, link_sif_o fwd.v = 0 and rev.v = 0.
- Issue 16 host requests with the network fwd always ready and no returns -> after 16 accepts, out_credits_o = 0, host_req_ready_o = 0, and a 17th request is held. Return 1 packet -> credits = 1 and the 17th request is accepted the next cycle.
- Same-cycle host accept and return accept with credits = 5 -> credits stay 5; the response FIFO holds 1 entry with matching data.
- Manycore sends a store from src (x=2, y=3, load_id=7) -> host_in_v_o = 1 with the identical packet. rev.v carries an e_return_credit to x=2, y=3, load_id=7. With rev ready held low for 10 cycles, fwd ready stays 0 for those 10 cycles.
- Fill the response FIFO (4 entries, host_rsp_yumi_i = 0) -> rev.ready_and_rev = 0. One yumi -> ready returns to 1 the next cycle, and FIFO order is preserved.
- With TIMEOUT_EN and timeout_cycles_p = 8, send 1 request with no return -> timeout_o rises exactly 8 cycles after the counter starts and stays high after a late return. Without the macro, timeout_o stays 0.
